// File: rtl/button_event_pkg.sv
// Shared types and default sizing for the button event capture block.
package button_event_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_t;

  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_LONG_CYCLES = 50_000_000;

endpackage

// File: rtl/button_event_channel.sv
// One button: level register, edge detect, sticky flags, press counter and hold FSM.
// Long-press detection is present only when BUTTON_EVENT_LONG_PRESS_EN is defined.
module button_event_channel
  import button_event_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button_level,
  input  logic             clear,
  output logic             level_out,
  output logic             press_flag,
  output logic             long_flag,
  output logic [CNT_W-1:0] press_count
);

  logic             level_q, level_prev_q;
  logic             press_flag_q, press_flag_d;
  logic [CNT_W-1:0] count_q, count_d;
  btn_state_t       state_q, state_d;
  logic             press_edge_c;

`ifdef BUTTON_EVENT_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_flag_q, long_flag_d;
  logic              long_set_c;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_flag_q <= 1'b0;
      count_q      <= '0;
      state_q      <= IDLE;
`ifdef BUTTON_EVENT_LONG_PRESS_EN
      hold_q       <= '0;
      long_flag_q  <= 1'b0;
`endif
    end else begin
      level_q      <= button_level;
      level_prev_q <= level_q;
      press_flag_q <= press_flag_d;
      count_q      <= count_d;
      state_q      <= state_d;
`ifdef BUTTON_EVENT_LONG_PRESS_EN
      hold_q       <= hold_d;
      long_flag_q  <= long_flag_d;
`endif
    end
  end

  // A set in the same cycle as a clear wins so no press is ever lost.
  always_comb begin
    press_edge_c = level_q & ~level_prev_q;
    press_flag_d = press_edge_c | (press_flag_q & ~clear);
    count_d      = press_edge_c ? count_q + CNT_W'(1) : count_q;
  end

`ifdef BUTTON_EVENT_LONG_PRESS_EN
  // Hold FSM; the counter stops at LONG_CYCLES so it never wraps.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    long_set_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q) begin
          state_d = PRESSED;
          hold_d  = HOLD_W'(1);
        end
      end
      PRESSED: begin
        if (!level_q) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
          if (hold_q == HOLD_W'(LONG_CYCLES - 1)) begin
            state_d    = HELD;
            long_set_c = 1'b1;
          end
        end
      end
      HELD: begin
        if (!level_q) begin
          state_d = IDLE;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
    long_flag_d = long_set_c | (long_flag_q & ~clear);
  end

  assign long_flag = long_flag_q;
`else
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (level_q)  state_d = PRESSED;
      PRESSED: if (!level_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign long_flag = 1'b0;
`endif

  assign level_out   = level_q;
  assign press_flag  = press_flag_q;
  assign press_count = count_q;

endmodule

// File: rtl/button_event_capture.sv
// Converts debounced button levels into sticky CPU events plus a single irq line.
// Define BUTTON_EVENT_LONG_PRESS_EN to enable long-press detection.
module button_event_capture
  import button_event_pkg::*;
#(
  parameter int unsigned N_BUTTONS   = 4,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_BUTTONS-1:0]       button_level,
  input  logic [N_BUTTONS-1:0]       clear,
  output logic [N_BUTTONS-1:0]       level_out,
  output logic [N_BUTTONS-1:0]       press_flag,
  output logic [N_BUTTONS-1:0]       long_flag,
  output logic [N_BUTTONS*CNT_W-1:0] press_count,
  output logic                       irq
);

  logic irq_q, irq_d;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    button_event_channel #(
      .CNT_W       (CNT_W),
      .LONG_CYCLES (LONG_CYCLES)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .button_level (button_level[i]),
      .clear        (clear[i]),
      .level_out    (level_out[i]),
      .press_flag   (press_flag[i]),
      .long_flag    (long_flag[i]),
      .press_count  (press_count[i*CNT_W +: CNT_W])
    );
  end

  always_comb begin
`ifdef BUTTON_EVENT_LONG_PRESS_EN
    irq_d = |(press_flag | long_flag);
`else
    irq_d = |press_flag;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;

endmodule
